seven_segment_scanner: RTL and testbench

//   Time-multiplexed driver for a DIGITS-wide common-anode/cathode 7-segment display.

---
 rtl/seven_segment_scanner.sv | 157 +++++++++++++++
 tb/tb_seven_segment_scanner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed BCD driver for a DIGITS-wide 7-segment display: one digit per
// REFRESH_DIV-cycle slot, gfedcba decode, leading-zero suppression, blanking and anode guard.
module seven_segment_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 1,
    parameter int SEG_ACT_LOW = 0,
    parameter int AN_ACT_LOW  = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   BCD,
    input  logic [DIGITS-1:0]     DP,
    input  logic                  LeadZero,
    input  logic                  Blank,
    output logic [6:0]            SevenSegment,
    output logic                  DecimalPoint,
    output logic [DIGITS-1:0]     Anode,
    output logic                  Frame
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Inactive levels double as XOR masks that turn active-high values into pin polarity.
    localparam logic [6:0]        SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACT_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [DIGITS-1:0] AN_ONE  = DIGITS'(1);

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0]    presc_r;
    logic [IDX_W-1:0]    index_r;
    logic [4*DIGITS-1:0] shadow_bcd_r;
    logic [DIGITS-1:0]   shadow_dp_r;
    logic [6:0]          seg_r;
    logic                dp_r;
    logic [DIGITS-1:0]   an_r;
    logic                frame_r;

    logic                slot_end_s;
    logic                last_digit_s;
    logic                guard_ok_s;
    logic [3:0]          digit_s [DIGITS];
    logic [DIGITS-1:0]   supp_s;
    logic                visible_s;
    logic [6:0]          seg_hi_s;
    logic                dp_hi_s;
    logic [DIGITS-1:0]   an_hi_s;

    assign slot_end_s   = (presc_r == CNT_W'(REFRESH_DIV - 1));
    assign last_digit_s = (index_r == IDX_W'(DIGITS - 1));

    generate
        if (GUARD == 0) begin : g_no_guard
            assign guard_ok_s = 1'b1;
        end else begin : g_guard
            assign guard_ok_s = (presc_r >= CNT_W'(GUARD));
        end
    endgenerate

    // Unpack the shadow word into per-digit nibbles.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            digit_s[i] = shadow_bcd_r[4*i +: 4];
        end
    end

    // Leading-zero mask: scanning down from the top, a digit is suppressed while every digit above it and itself is 0.
    always_comb begin : p_supp
        logic zero_run;
        zero_run = 1'b1;
        supp_s   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (digit_s[i] == 4'd0);
            if (LeadZero && zero_run && (i != 0)) begin
                supp_s[i] = 1'b1;
            end else begin
                supp_s[i] = 1'b0;
            end
        end
    end

    // Active-high next-output values for the digit currently being scanned.
    always_comb begin
        visible_s = !Blank && !supp_s[index_r];
        if (visible_s) begin
            seg_hi_s = seg_decode(digit_s[index_r]);
            dp_hi_s  = shadow_dp_r[index_r];
        end else begin
            seg_hi_s = 7'b0000000;
            dp_hi_s  = 1'b0;
        end
        if (visible_s && guard_ok_s) begin
            an_hi_s = AN_ONE << index_r;
        end else begin
            an_hi_s = {DIGITS{1'b0}};
        end
    end

    // Scan counters, shadow capture and registered display outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc_r      <= '0;
            index_r      <= '0;
            shadow_bcd_r <= '0;
            shadow_dp_r  <= '0;
            seg_r        <= SEG_OFF;
            dp_r         <= DP_OFF;
            an_r         <= AN_OFF;
            frame_r      <= 1'b0;
        end else begin
            if (slot_end_s) begin
                presc_r <= '0;
                if (last_digit_s) begin
                    index_r <= '0;
                end else begin
                    index_r <= index_r + IDX_W'(1);
                end
            end else begin
                presc_r <= presc_r + CNT_W'(1);
            end
            if (Load) begin
                shadow_bcd_r <= BCD;
                shadow_dp_r  <= DP;
            end
            seg_r   <= seg_hi_s ^ SEG_OFF;
            dp_r    <= dp_hi_s ^ DP_OFF;
            an_r    <= an_hi_s ^ AN_OFF;
            frame_r <= slot_end_s && last_digit_s;
        end
    end

    assign SevenSegment = seg_r;
    assign DecimalPoint = dp_r;
    assign Anode        = an_r;
    assign Frame        = frame_r;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner: an active-high and an active-low instance
// (DIGITS=4, REFRESH_DIV=4, GUARD=1) driven from shared inputs.
module tb_seven_segment_scanner;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Load = 1'b0;
    logic [15:0] BCD = 16'h0000;
    logic [3:0]  DP = 4'b0000;
    logic        LeadZero = 1'b0;
    logic        Blank = 1'b0;

    logic [6:0]  seg_h, seg_l;
    logic        dp_h, dp_l;
    logic [3:0]  an_h, an_l;
    logic        frame_h, frame_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Active-high gfedcba patterns for codes 0..15.
    localparam logic [6:0] SEG_TBL [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b0000000, 7'b0000000,
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

    seven_segment_scanner #(
        .DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .SEG_ACT_LOW(0), .AN_ACT_LOW(0)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Load(Load), .BCD(BCD), .DP(DP),
        .LeadZero(LeadZero), .Blank(Blank),
        .SevenSegment(seg_h), .DecimalPoint(dp_h), .Anode(an_h), .Frame(frame_h)
    );

    seven_segment_scanner #(
        .DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
    ) dut_n (
        .Clk(Clk), .Reset(Reset), .Load(Load), .BCD(BCD), .DP(DP),
        .LeadZero(LeadZero), .Blank(Blank),
        .SevenSegment(seg_l), .DecimalPoint(dp_l), .Anode(an_l), .Frame(frame_l)
    );

    always #5 Clk = ~Clk;

    // Expected active-high anode after edge k (edge 1 is the first edge after release).
    function automatic logic [3:0] exp_anode(input int k);
        int s, p;
        s = ((k - 1) / 4) % 4;
        p = (k - 1) % 4;
        return (p >= 1) ? (4'b0001 << s) : 4'b0000;
    endfunction

    // Hold reset two edges with the given inputs, release, let edge 1 capture them.
    task automatic apply_reset(input logic [15:0] bcd, input logic [3:0] dp, input logic lz);
        Reset = 1'b1; Load = 1'b1; BCD = bcd; DP = dp; LeadZero = lz; Blank = 1'b0;
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        Load = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Load = 1'b0; BCD = 16'h0000; DP = 4'b0000; LeadZero = 1'b0; Blank = 1'b0;
        @(posedge Clk); @(posedge Clk); #1;
        n_checks++;
        if ({seg_h, dp_h, an_h, frame_h} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_high: got seg=%b dp=%b an=%b frame=%b want all 0", seg_h, dp_h, an_h, frame_h);
        end
        n_checks++;
        if ({seg_l, dp_l, an_l, frame_l} !== {7'h7f, 1'b1, 4'hf, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_low: got seg=%b dp=%b an=%b frame=%b want 1111111 1 1111 0", seg_l, dp_l, an_l, frame_l);
        end
        Reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge Clk); #1;
            n_checks++;
            if (an_h !== exp_anode(k)) begin
                n_fail++;
                $display("FAIL scan_anode k=%0d: got %b want %b", k, an_h, exp_anode(k));
            end
            n_checks++;
            if (frame_h !== ((k % 16) == 0)) begin
                n_fail++;
                $display("FAIL frame k=%0d: got %b want %b", k, frame_h, ((k % 16) == 0));
            end
            n_checks++;
            if (seg_h !== 7'b0111111) begin
                n_fail++;
                $display("FAIL reset_seg k=%0d: got %b want 0111111", k, seg_h);
            end
        end
    endtask

    task automatic test_decode;
        logic [15:0] v;
        v = 16'h1234;
        apply_reset(v, 4'b0100, 1'b0);
        for (int k = 2; k <= 16; k++) begin
            int s, p;
            @(posedge Clk); #1;
            s = (k - 1) / 4;
            p = (k - 1) % 4;
            n_checks++;
            if (an_h !== exp_anode(k) || an_l !== ~exp_anode(k)) begin
                n_fail++;
                $display("FAIL decode_anode k=%0d: got %b/%b want %b", k, an_h, an_l, exp_anode(k));
            end
            if (p >= 1) begin
                n_checks++;
                if (seg_h !== SEG_TBL[v[4*s +: 4]] || seg_l !== ~SEG_TBL[v[4*s +: 4]]) begin
                    n_fail++;
                    $display("FAIL decode_seg k=%0d: got %b/%b want %b", k, seg_h, seg_l, SEG_TBL[v[4*s +: 4]]);
                end
                n_checks++;
                if (dp_h !== (s == 2)) begin
                    n_fail++;
                    $display("FAIL decode_dp k=%0d: got %b want %b", k, dp_h, (s == 2));
                end
            end
        end
    endtask

    task automatic test_lead_zero;
        logic [15:0] v;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        for (int pass = 0; pass < 2; pass++) begin
            v = (pass == 0) ? 16'h0042 : 16'h0000;
            apply_reset(v, 4'b1111, 1'b1);
            for (int k = 2; k <= 16; k++) begin
                int s, p;
                logic vis;
                @(posedge Clk); #1;
                s = (k - 1) / 4;
                p = (k - 1) % 4;
                vis = (pass == 0) ? (s <= 1) : (s == 0);
                exp_an  = vis ? exp_anode(k) : 4'b0000;
                exp_seg = vis ? SEG_TBL[v[4*s +: 4]] : 7'b0000000;
                n_checks++;
                if (an_h !== exp_an) begin
                    n_fail++;
                    $display("FAIL lz_anode pass=%0d k=%0d: got %b want %b", pass, k, an_h, exp_an);
                end
                if (p >= 1) begin
                    n_checks++;
                    if (seg_h !== exp_seg || dp_h !== vis) begin
                        n_fail++;
                        $display("FAIL lz_seg pass=%0d k=%0d: got %b dp=%b want %b dp=%b", pass, k, seg_h, dp_h, exp_seg, vis);
                    end
                end
            end
        end
        LeadZero = 1'b0;
    endtask

    task automatic test_invalid_code;
        logic [15:0] v;
        v = 16'hF0A0;
        apply_reset(v, 4'b0000, 1'b0);
        for (int k = 2; k <= 16; k++) begin
            int s, p;
            @(posedge Clk); #1;
            s = (k - 1) / 4;
            p = (k - 1) % 4;
            if (p >= 1) begin
                n_checks++;
                if (seg_h !== SEG_TBL[v[4*s +: 4]] || an_h !== exp_anode(k)) begin
                    n_fail++;
                    $display("FAIL invalid_code k=%0d: got seg=%b an=%b want seg=%b an=%b", k, seg_h, an_h, SEG_TBL[v[4*s +: 4]], exp_anode(k));
                end
            end
        end
    endtask

    task automatic test_blank;
        logic [3:0] exp_an;
        apply_reset(16'h1234, 4'b0000, 1'b0);
        for (int k = 2; k <= 24; k++) begin
            Blank = (k >= 7 && k <= 16);
            @(posedge Clk); #1;
            exp_an = (k >= 7 && k <= 16) ? 4'b0000 : exp_anode(k);
            n_checks++;
            if (an_h !== exp_an) begin
                n_fail++;
                $display("FAIL blank_anode k=%0d: got %b want %b", k, an_h, exp_an);
            end
            n_checks++;
            if (frame_h !== (k == 16)) begin
                n_fail++;
                $display("FAIL blank_frame k=%0d: got %b want %b", k, frame_h, (k == 16));
            end
        end
        Blank = 1'b0;
    endtask

    task automatic test_load_timing;
        apply_reset(16'h1234, 4'b0000, 1'b0);
        // Edges 2,3 pass; new value loaded at edge 4, the slot 0 -> 1 boundary.
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        BCD = 16'h5678; Load = 1'b1;
        @(posedge Clk); #1;
        Load = 1'b0;
        n_checks++;
        if (seg_h !== 7'b1100110) begin
            n_fail++;
            $display("FAIL load_old k=4: got %b want 1100110", seg_h);
        end
        @(posedge Clk); #1;
        n_checks++;
        if (seg_h !== 7'b0000111) begin
            n_fail++;
            $display("FAIL load_slot_edge k=5: got %b want 0000111", seg_h);
        end
        // Mid-slot reload at edge 6: edge 6 still shows 7, edge 7 shows 9.
        BCD = 16'h5698; Load = 1'b1;
        @(posedge Clk); #1;
        Load = 1'b0;
        n_checks++;
        if (seg_h !== 7'b0000111 || an_h !== 4'b0010) begin
            n_fail++;
            $display("FAIL load_mid_old k=6: got %b an=%b want 0000111 an=0010", seg_h, an_h);
        end
        @(posedge Clk); #1;
        n_checks++;
        if (seg_h !== 7'b1101111) begin
            n_fail++;
            $display("FAIL load_mid_new k=7: got %b want 1101111", seg_h);
        end
    endtask

    task automatic test_active_low_async_reset;
        apply_reset(16'h0008, 4'b0000, 1'b0);
        @(posedge Clk); #1;
        n_checks++;
        if (seg_l !== 7'b0000000 || an_l !== 4'b1110 || dp_l !== 1'b1) begin
            n_fail++;
            $display("FAIL active_low_8: got seg=%b an=%b dp=%b want 0000000 1110 1", seg_l, an_l, dp_l);
        end
        #2;
        Reset = 1'b1;
        #1;
        n_checks++;
        if (seg_l !== 7'h7f || an_l !== 4'hf || dp_l !== 1'b1 || seg_h !== 7'h00 || an_h !== 4'h0) begin
            n_fail++;
            $display("FAIL async_reset: got low seg=%b an=%b dp=%b high seg=%b an=%b", seg_l, an_l, dp_l, seg_h, an_h);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_lead_zero();
        test_invalid_code();
        test_blank();
        test_load_timing();
        test_active_low_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
